// File: rtl/async_sync_sink.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// async_sync_sink
//
// Clocked consumer for the asynchronous arbitrated merge. The merge presents a
// two-phase (transition-signalled) drive/free handshake with bundled data.
// This block brings each drive transition into the clk domain through a
// synchroniser, captures the bundled word into a first-word-fall-through
// FIFO, answers with a free transition, and offers the FIFO head to
// synchronous logic as a valid/ready stream.
//
// Ports
//   clk      : single clock for all state
//   rst      : asynchronous, active-high reset
//   i_drive  : two-phase request; every level change is one token
//   i_data   : bundled data, held by the merge until o_free changes
//   o_free   : two-phase acknowledge; every level change frees one token
//   o_valid  : FIFO head is valid
//   o_data   : FIFO head word (zero while empty)
//   i_ready  : downstream takes the head when o_valid & i_ready at clk rise
//   o_count  : FIFO occupancy, 0..DEPTH
//   o_err    : sticky flag, a second token arrived before the first was freed
// -----------------------------------------------------------------------------
module async_sync_sink #(
   parameter int DATA_WIDTH  = 105,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_drive,
   input  logic [DATA_WIDTH-1:0]     i_data,
   output logic                      o_free,
   output logic                      o_valid,
   output logic [DATA_WIDTH-1:0]     o_data,
   input  logic                      i_ready,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Elaboration-time guard on the parameter ranges the pointer logic relies on.
   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("async_sync_sink: DEPTH must be a power of two and at least 2");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("async_sync_sink: SYNC_STAGES must be at least 2");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,   // tokens are accepted as they arrive
      ST_HOLD = 1'b1    // one token is parked waiting for a free FIFO slot
   } state_t;

   // ---------------------------------------------------------------- state
   logic [SYNC_STAGES-1:0] sync_q,   sync_d;
   logic                   d_prev_q, d_prev_d;
   state_t                 state_q,  state_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q,  count_d;
   logic                   free_q,   free_d;
   logic                   err_q,    err_d;
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

   // ---------------------------------------------------------------- decode
   logic tok_s;       // one-cycle pulse per synchronised drive transition
   logic full_s;      // occupancy before this edge's pop
   logic push_s;
   logic pop_s;
   logic err_set_s;

   // Synchroniser shift, previous-level tracking and token edge detection.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], i_drive};
      d_prev_d = sync_q[SYNC_STAGES-1];
      tok_s    = sync_q[SYNC_STAGES-1] ^ d_prev_q;
   end

   // Full is judged on the pre-pop count: a pop never makes room for a push
   // on the same edge, which keeps the write path independent of i_ready.
   always_comb begin
      full_s = (count_q == CNT_W'(DEPTH));
      pop_s  = (count_q != {CNT_W{1'b0}}) & i_ready;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (tok_s && full_s) begin
               state_d = ST_HOLD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (!full_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: when to write the bundled word and when a token is illegal.
   // In HOLD the parked token is written as soon as a slot exists; no new
   // token may arrive there because its predecessor has not been freed.
   always_comb begin
      push_s    = 1'b0;
      err_set_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            push_s    = tok_s & ~full_s;
            err_set_s = 1'b0;
         end
         ST_HOLD: begin
            push_s    = ~full_s;
            err_set_s = tok_s;
         end
         default: begin
            push_s    = 1'b0;
            err_set_s = 1'b0;
         end
      endcase
   end

   // Pointer, occupancy, acknowledge and error-flag next values.
   always_comb begin
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1'b1);
         2'b01:   count_d = count_q - CNT_W'(1'b1);
         default: count_d = count_q;
      endcase

      // Every write frees exactly one token back to the merge.
      free_d = free_q ^ push_s;
      err_d  = err_q | err_set_s;
   end

   // Control registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q   <= {SYNC_STAGES{1'b0}};
         d_prev_q <= 1'b0;
         state_q  <= ST_IDLE;
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         free_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         d_prev_q <= d_prev_d;
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         free_q   <= free_d;
         err_q    <= err_d;
      end
   end

   // Storage array. i_data is taken without synchronisation: the merge holds
   // it steady from its drive transition until it sees o_free change.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   // ---------------------------------------------------------------- outputs
   // Stale memory is masked while empty so o_data reads zero out of reset.
   always_comb begin
      o_valid = (count_q != {CNT_W{1'b0}});
      if (o_valid) begin
         o_data = mem_q[rd_ptr_q];
      end else begin
         o_data = {DATA_WIDTH{1'b0}};
      end
      o_count = count_q;
      o_free  = free_q;
      o_err   = err_q;
   end

endmodule

// File: tb/tb_async_sync_sink.sv
`timescale 1ns/1ps
module tb_async_sync_sink;

   localparam int DW    = 105;
   localparam int DEPTH = 4;
   localparam int SS    = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_drive;
   logic [DW-1:0] i_data;
   logic          o_free;
   logic          o_valid;
   logic [DW-1:0] o_data;
   logic          i_ready;
   logic [CW-1:0] o_count;
   logic          o_err;

   int total = 0;
   int bad   = 0;

   async_sync_sink #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_drive (i_drive),
      .i_data  (i_data),
      .o_free  (o_free),
      .o_valid (o_valid),
      .o_data  (o_data),
      .i_ready (i_ready),
      .o_count (o_count),
      .o_err   (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          drive;
      logic [15:0]   data;
      logic          ready;
      logic          exp_free;
      logic          exp_valid;
      logic [CW-1:0] exp_count;
      logic [15:0]   exp_data;
      logic          exp_err;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      i_drive = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Issue one token and wait (bounded) for the matching free transition.
   task automatic send_token(input logic [DW-1:0] d);
      int n;
      i_data  = d;
      i_drive = !i_drive;
      n = 0;
      while (o_free !== i_drive && n < 12) begin
         tick();
         n++;
      end
      chk("token_freed", o_free, i_drive);
   endtask

   // Random traffic against a transaction-level model: a token becomes
   // eligible SS edges after its drive change and is written at the first
   // eligible edge that sees the FIFO (pre-pop) not full.
   task automatic run_model(input int ntok, input bit always_ready, input string tag);
      logic [DW-1:0]  q[$];
      logic [DW-1:0]  pend_data;
      logic [127:0]   rnd;
      bit             pend, push, pop;
      logic           free_m;
      int             pend_edge, sent, got, e;
      do_reset();
      pend = 0; free_m = 1'b0; sent = 0; got = 0; e = 0; pend_edge = 0;
      pend_data = '0;
      while (got < ntok && e < 3000) begin
         if (!pend && sent < ntok && $urandom_range(0, 3) != 0) begin
            rnd       = {$urandom(), $urandom(), $urandom(), $urandom()};
            i_data    = rnd[DW-1:0];
            i_drive   = !i_drive;
            pend      = 1;
            pend_edge = e + SS;
            pend_data = i_data;
            sent++;
         end
         i_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
         push = pend && (e >= pend_edge) && (q.size() < DEPTH);
         pop  = (q.size() > 0) && (i_ready == 1'b1);
         if (pop) begin
            void'(q.pop_front());
            got++;
         end
         if (push) begin
            q.push_back(pend_data);
            pend   = 0;
            free_m = !free_m;
         end
         tick();
         e++;
         chk({tag, "_count"}, o_count, q.size());
         chk({tag, "_valid"}, o_valid, (q.size() != 0));
         chk({tag, "_data"},  o_data,  (q.size() != 0) ? q[0] : '0);
         chk({tag, "_free"},  o_free,  free_m);
         chk({tag, "_err"},   o_err,   1'b0);
         if (always_ready) chk({tag, "_count_le1"}, (o_count <= 1), 1'b1);
      end
      chk({tag, "_delivered"}, got, ntok);
      chk({tag, "_empty_end"}, q.size(), 0);
      i_ready = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] got_words[$];
      int n;

      // {drive, data, ready} -> {free, valid, count, data, err}, one edge each
      vecs[0] = '{1'b1, 16'h005A, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 16'h005A, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
      vecs[2] = '{1'b1, 16'h005A, 1'b0, 1'b1, 1'b1, 3'd1, 16'h005A, 1'b0};
      vecs[3] = '{1'b1, 16'h005A, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
      vecs[4] = '{1'b0, 16'h0033, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
      vecs[5] = '{1'b0, 16'h0033, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0};
      vecs[6] = '{1'b0, 16'h0033, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0033, 1'b0};
      vecs[7] = '{1'b0, 16'h0033, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
      vecs[8] = '{1'b0, 16'h0033, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};

      rst = 1'b1; i_drive = 1'b0; i_ready = 1'b0; i_data = '0;
      #2;
      chk("rst_free",  o_free,  1'b0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_count", o_count, 0);
      chk("rst_err",   o_err,   1'b0);
      chk("rst_data",  o_data,  0);
      do_reset();

      // Latency, first capture, pops and idle-ready behaviour.
      for (int i = 0; i < 9; i++) begin
         i_drive = vecs[i].drive;
         i_data  = DW'(vecs[i].data);
         i_ready = vecs[i].ready;
         tick();
         chk($sformatf("vec%0d_free", i),  o_free,  vecs[i].exp_free);
         chk($sformatf("vec%0d_valid", i), o_valid, vecs[i].exp_valid);
         chk($sformatf("vec%0d_count", i), o_count, vecs[i].exp_count);
         chk($sformatf("vec%0d_data", i),  o_data,  DW'(vecs[i].exp_data));
         chk($sformatf("vec%0d_err", i),   o_err,   vecs[i].exp_err);
      end

      // Fill, park a fifth token, pop with it pending, then drain in order.
      do_reset();
      for (int k = 1; k <= 4; k++) send_token(DW'(k));
      chk("fill_count", o_count, 4);
      i_data  = DW'(5);
      i_drive = !i_drive;
      repeat (6) tick();
      chk("hold_free_unchanged", o_free, !i_drive);
      chk("hold_count", o_count, 4);
      chk("hold_err", o_err, 1'b0);
      got_words.push_back(o_data);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("pop_edge_count", o_count, 3);
      chk("pop_edge_no_push", o_free, !i_drive);
      tick();
      chk("held_write_count", o_count, 4);
      chk("held_write_free", o_free, i_drive);
      i_ready = 1'b1;
      n = 0;
      while (o_valid && n < 20) begin
         got_words.push_back(o_data);
         tick();
         n++;
      end
      i_ready = 1'b0;
      chk("drain_len", got_words.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < got_words.size()) chk($sformatf("drain_word%0d", k), got_words[k], k + 1);
      end
      chk("drain_count", o_count, 0);

      // Second token while parked sets the sticky error; reset clears everything.
      do_reset();
      for (int k = 1; k <= 4; k++) send_token(DW'(k + 16));
      i_data  = DW'(5);
      i_drive = !i_drive;
      repeat (4) tick();
      chk("err_before", o_err, 1'b0);
      i_drive = !i_drive;
      repeat (4) tick();
      chk("err_set", o_err, 1'b1);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("err_hold_count3", o_count, 3);
      chk("err_sticky", o_err, 1'b1);
      rst = 1'b1;
      i_drive = 1'b0;
      #1;
      chk("async_rst_free",  o_free,  1'b0);
      chk("async_rst_valid", o_valid, 1'b0);
      chk("async_rst_count", o_count, 0);
      chk("async_rst_err",   o_err,   1'b0);
      chk("async_rst_data",  o_data,  0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      send_token(DW'(16'hC3));
      chk("post_rst_valid", o_valid, 1'b1);
      chk("post_rst_data",  o_data,  16'hC3);
      chk("post_rst_count", o_count, 1);
      chk("post_rst_err",   o_err,   1'b0);

      // Streaming with ready held high, then random backpressure.
      run_model(16, 1'b1, "stream");
      run_model(60, 1'b0, "rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/async_sync_sink.md
Name: async_sync_sink

Overview:
- Clocked consumer placed directly downstream of the asynchronous arbitrated merge stage.
- Takes the merge's two-phase drive/free bundled-data channel, synchronises the drive event into the clk domain, and captures the bundled data into a first-word-fall-through FIFO.
- Returns the free acknowledgement to the merge and presents the data as a valid/ready stream to synchronous logic such as the matrix compute core.
- Also reports occupancy and a sticky protocol-error flag.

Parameters:
- DATA_WIDTH, 105, width of the bundled data word; matches the merge output.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flops in the i_drive synchroniser; at least 2.

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  asynchronous, active-high reset.
- i_drive  input  1  two-phase request from the merge; each level transition is one token.
- i_data  input  DATA_WIDTH  bundled data; stable from the i_drive transition until o_free toggles.
- o_free  output  1  two-phase acknowledge to the merge; each toggle frees one token.
- o_valid  output  1  FIFO head is valid.
- o_data  output  DATA_WIDTH  FIFO head word (FWFT).
- i_ready  input  1  downstream accepts the head word when o_valid and i_ready are both 1 at a rising clk edge.
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- o_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1, asynchronous):
  - o_free=0, o_valid=0, o_count=0, o_err=0, o_data=0.
  - Synchroniser chain, previous-level flop, pointers and state are cleared.
  - Memory contents are don't-care, but o_data is forced to 0 while empty.
  - The merge resets at the same time, so i_drive=0 is the idle level after reset.
- Synchroniser:
  - s[0] <= i_drive; s[k] <= s[k-1].
  - d_prev <= s[SYNC_STAGES-1].
  - tok = s[SYNC_STAGES-1] ^ d_prev, a one-cycle pulse per token.
- FSM states IDLE and HOLD:
  - IDLE with tok=1 and count<DEPTH: write i_data into mem[wr_ptr], increment wr_ptr, toggle o_free at the same edge, stay in IDLE.
  - IDLE with tok=1 and count==DEPTH: go to HOLD. Do not write and do not toggle o_free.
  - HOLD, at the first edge with count<DEPTH: write, toggle o_free, go to IDLE.
  - A pop on the same edge does not free a slot for that edge's push; the push decision uses count before the pop.
- Latency: for an i_drive toggle meeting setup before edge 0, the write and the o_free toggle occur at edge SYNC_STAGES (edge 2 when SYNC_STAGES=2). o_valid rises after that edge.
- Data capture: i_data is sampled unsynchronised at the write edge. This is safe by the bundled-data rule, because the merge holds its data until o_free toggles.
- Pop:
  - When o_valid & i_ready, increment rd_ptr.
  - Pointers wrap modulo DEPTH.
  - o_valid = (count != 0).
  - o_data = mem[rd_ptr] while count != 0.
- Count update:
  - Increments on push only, decrements on pop only, unchanged on simultaneous push and pop.
  - Never exceeds DEPTH and never underflows.
- Protocol error: o_err sets and stays set until rst in either case:
  - tok=1 while in HOLD, meaning a second token arrived before the free.
  - i_ready=1 with o_valid=0 has no effect and is not an error.
- Reset mid-operation: pending HOLD tokens and FIFO contents are discarded. The FSM returns to IDLE.

Test Plan:
- Reset, then toggle i_drive 0→1 with i_data=0x5A before edge 0, i_ready=0 -> o_free 0→1 at edge 2; after edge 2 o_valid=1, o_data=0x5A, o_count=1.
- Send 4 tokens 0x1..0x4 (toggle i_drive after each o_free toggle), i_ready=0 -> o_count=4. A 5th token 0x5 leaves o_free unchanged and FSM in HOLD. One pop returns 0x1; at the next edge 0x5 is written, o_free toggles and o_count stays 4.
- Full FIFO with i_ready=1 and a pending token on the same edge -> pop happens and push waits one edge. Output order is exactly 0x1,0x2,0x3,0x4,0x5 with no loss or duplication.
- In HOLD, toggle i_drive again without waiting for o_free -> o_err=1 and stays 1 through later traffic until rst.
- Stream 16 tokens with i_ready held at 1 -> all 16 words are delivered in order and pointers wrap cleanly. o_count never exceeds 1 after the first push and returns to 0.
- Assert rst with o_count=3 and the FSM in HOLD -> all outputs are 0 immediately (asynchronous). After deassert, one new token is delivered normally.
